register_file_16x32: RTL and testbench

Sixteen-entry, 32-bit general-purpose register file for the ARM datapath. It sits directly downstream of the 4-to-16 write-address decoder and consumes that decoder's one-hot output as its per-register write select. It provides three combinational read ports for Rn, Rm and Rd/store data. R15 also serves as the program counter, with its own increment path.

---
 rtl/register_file_16x32_pkg.sv | 19 +
 rtl/register_file_16x32_register_32.sv | 34 +++
 rtl/register_file_16x32.sv | 90 +++++++++
 tb/tb_register_file_16x32.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_16x32_pkg.sv
// Shared constants and helpers for the 16x32 ARM register file.
// R15 doubles as the program counter and is read with a pipeline offset.
package register_file_16x32_pkg;

  localparam int         NUM_REGS = 16;
  localparam int         SEL_W    = NUM_REGS;
  localparam logic [3:0] REG_PC   = 4'd15;
  localparam int         PC_STEP  = 4;

  function automatic logic [4:0] popcount(input logic [SEL_W-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < SEL_W; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/register_file_16x32_register_32.sv
// Single DATA_W-bit register with load enable and a parameterised
// asynchronous reset value.
module register_32 #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file_16x32.sv
// Sixteen-entry register file with three combinational read ports, a one-hot
// write select and an R15 program counter with its own increment path.
module register_file_16x32
  import register_file_16x32_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] PC_RESET       = '0,
  parameter logic [DATA_W-1:0] PC_READ_OFFSET = DATA_W'(8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SEL_W-1:0]  we_1h,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        sel_a,
  input  logic [3:0]        sel_b,
  input  logic [3:0]        sel_c,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_c,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc,
  output logic              wr_err
);

  logic [4:0]          sel_cnt;
  logic                legal_wr;
  logic                multi_wr;
  logic                wr_pc;
  logic [NUM_REGS-1:0] load_en;
  logic [DATA_W-1:0]   load_data [NUM_REGS];
  logic [DATA_W-1:0]   reg_q     [NUM_REGS];
  logic                wr_err_q;
  logic                wr_err_d;

  // A select that is not exactly one-hot must never touch any register.
  assign sel_cnt  = popcount(we_1h);
  assign legal_wr = we && (sel_cnt == 5'd1);
  assign multi_wr = we && (sel_cnt > 5'd1);
  assign wr_pc    = legal_wr && we_1h[REG_PC];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      load_en[i]   = legal_wr && we_1h[i];
      load_data[i] = wr_data;
    end
    // R15: explicit write beats increment, otherwise hold.
    load_en[REG_PC]   = wr_pc || pc_inc;
    load_data[REG_PC] = wr_pc ? wr_data : reg_q[REG_PC] + DATA_W'(PC_STEP);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      register_32 #(
        .DATA_W    (DATA_W),
        .RESET_VAL ((gi == NUM_REGS - 1) ? PC_RESET : '0)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en[gi]),
        .d     (load_data[gi]),
        .q     (reg_q[gi])
      );
    end
  endgenerate

  always_comb begin
    wr_err_d = wr_err_q || multi_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  // Reads of R15 see the pipelined PC value, the fetch path sees it raw.
  always_comb begin
    rd_a = (sel_a == REG_PC) ? reg_q[REG_PC] + PC_READ_OFFSET : reg_q[sel_a];
    rd_b = (sel_b == REG_PC) ? reg_q[REG_PC] + PC_READ_OFFSET : reg_q[sel_b];
    rd_c = (sel_c == REG_PC) ? reg_q[REG_PC] + PC_READ_OFFSET : reg_q[sel_c];
  end

  assign pc     = reg_q[REG_PC];
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_register_file_16x32.sv
// Scoreboard bench for register_file_16x32: expected values are queued when
// stimulus is driven and popped once the DUT output is due.
module tb_register_file_16x32;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [15:0] we_1h;
  logic [31:0] wr_data;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        pc_inc;
  logic [31:0] pc;
  logic        wr_err;

  exp_t        exp_q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [16];
  logic        err_m;

  register_file_16x32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .we_1h   (we_1h),
    .wr_data (wr_data),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel_c   (sel_c),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .rd_c    (rd_c),
    .pc_inc  (pc_inc),
    .pc      (pc),
    .wr_err  (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 15; i++) model[i] = 32'h0;
    model[15] = 32'h0;
    err_m = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sel_a = 4'd3;
    sel_c = 4'd15;
    model_reset();
    exp_q.push_back('{"reset_pc", model[15]});
    exp_q.push_back('{"reset_rd_a", model[3]});
    exp_q.push_back('{"reset_rd_c_r15", model[15] + 32'd8});
    exp_q.push_back('{"reset_wr_err", {31'd0, err_m}});
    #1;
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_c !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_c, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_walking_write();
    for (int i = 0; i < 15; i++) begin
      sel_b   = 4'(i);
      we      = 1'b1;
      we_1h   = 16'h1 << i;
      wr_data = 32'hA5A5_0000 + 32'(i);
      exp_q.push_back('{$sformatf("walk_pre_r%0d", i), model[i]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd_b !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_b, e.val); end
      model[i] = wr_data;
      exp_q.push_back('{$sformatf("walk_post_r%0d", i), model[i]});
      step();
      e = exp_q.pop_front(); checks++;
      if (rd_b !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_b, e.val); end
    end
    we    = 1'b0;
    we_1h = '0;
  endtask

  task automatic test_zero_and_disabled();
    we = 1'b1; we_1h = 16'h0; wr_data = 32'hFFFF_FFFF; sel_a = 4'd0;
    exp_q.push_back('{"zero_sel_r0", model[0]});
    exp_q.push_back('{"zero_sel_err", {31'd0, err_m}});
    step();
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
    we = 1'b0; we_1h = 16'h0011;
    exp_q.push_back('{"we0_r0", model[0]});
    exp_q.push_back('{"we0_err", {31'd0, err_m}});
    step();
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
  endtask

  task automatic test_illegal_select();
    we = 1'b1; we_1h = 16'h0011; wr_data = 32'h0000_DEAD;
    sel_a = 4'd0; sel_b = 4'd4;
    err_m = 1'b1;
    exp_q.push_back('{"illegal_r0", model[0]});
    exp_q.push_back('{"illegal_r4", model[4]});
    exp_q.push_back('{"illegal_err", {31'd0, err_m}});
    step();
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_b !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_b, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
    we_1h = 16'h0020; wr_data = 32'h0000_0055; sel_c = 4'd5;
    model[5] = wr_data;
    exp_q.push_back('{"sticky_r5", model[5]});
    exp_q.push_back('{"sticky_err", {31'd0, err_m}});
    step();
    e = exp_q.pop_front(); checks++;
    if (rd_c !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_c, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
    we = 1'b0; we_1h = '0;
  endtask

  task automatic test_r15_priority();
    we = 1'b1; we_1h = 16'h8000; wr_data = 32'h0000_0100; pc_inc = 1'b1; sel_a = 4'd15;
    model[15] = 32'h0000_0100;
    exp_q.push_back('{"prio_pc", model[15]});
    exp_q.push_back('{"prio_rd_a", 32'h0000_0108});
    step();
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    we = 1'b0; we_1h = '0;
    model[15] = 32'h0000_0104;
    exp_q.push_back('{"inc_pc", model[15]});
    step();
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    pc_inc = 1'b0;
  endtask

  task automatic test_pc_wrap();
    we = 1'b1; we_1h = 16'h8000; wr_data = 32'hFFFF_FFFC; sel_c = 4'd15;
    model[15] = 32'hFFFF_FFFC;
    exp_q.push_back('{"wrap_load_pc", model[15]});
    step();
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    we = 1'b0; we_1h = '0; pc_inc = 1'b1;
    model[15] = 32'h0;
    exp_q.push_back('{"wrap_pc", model[15]});
    exp_q.push_back('{"wrap_rd_c", 32'h0000_0008});
    step();
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_c !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_c, e.val); end
    pc_inc = 1'b0;
  endtask

  task automatic test_concurrent();
    we = 1'b1; we_1h = 16'h0004; wr_data = 32'h1234_5678; pc_inc = 1'b1; sel_b = 4'd2;
    model[2]  = wr_data;
    model[15] = 32'h0000_0004;
    exp_q.push_back('{"conc_r2", model[2]});
    exp_q.push_back('{"conc_pc", model[15]});
    step();
    e = exp_q.pop_front(); checks++;
    if (rd_b !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_b, e.val); end
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    we = 1'b0; we_1h = '0; pc_inc = 1'b0;
  endtask

  task automatic test_async_reset();
    sel_a = 4'd15; sel_b = 4'd2; sel_c = 4'd5;
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back('{"arst_pc", model[15]});
    exp_q.push_back('{"arst_r2", model[2]});
    exp_q.push_back('{"arst_r5", model[5]});
    exp_q.push_back('{"arst_rd_a_r15", 32'h0000_0008});
    exp_q.push_back('{"arst_err", {31'd0, err_m}});
    #1;
    e = exp_q.pop_front(); checks++;
    if (pc !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, pc, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_b !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_b, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_c !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_c, e.val); end
    e = exp_q.pop_front(); checks++;
    if (rd_a !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_a, e.val); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, wr_err} !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; we_1h = '0; wr_data = '0;
    sel_a = '0; sel_b = '0; sel_c = '0; pc_inc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_walking_write();
    test_zero_and_disabled();
    test_illegal_select();
    test_r15_priority();
    test_pc_wrap();
    test_concurrent();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
